// File: rtl/dmem_responder.sv
// Data-memory responder for the pipeline MEM stage.
// Single-ported 2^ADDR_W x 16-bit word array behind a three-state handshake
// (IDLE -> WAIT -> RESP). Each access pays WAIT_CYCLES wait states and then
// ends with a one-cycle ready pulse. stall holds the pipeline while a request
// is outstanding.
// Optional feature: define DMEM_RANGE_CHECK_EN to reject addresses whose bits
// above ADDR_W are nonzero. A rejected access still completes with ready, but
// it suppresses the write, returns zero on a read, and flags err in the RESP
// cycle. Without the macro the upper address bits alias onto the array.
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [15:0] address,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        ready,
  output logic        stall,
  output logic        err
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam bit         HAS_WAIT = (WAIT_CYCLES != 0);
  localparam logic [3:0] CNT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [15:0]       mem [DEPTH];

  logic              req;
  logic              complete;     // this edge moves the FSM into RESP
  logic              range_fault;
  logic              do_write;
  logic              do_read;
  logic [ADDR_W-1:0] idx;

  assign req   = memread | memwrite;
  assign idx   = address[ADDR_W-1:0];
  assign stall = req & ~ready;

`ifdef DMEM_RANGE_CHECK_EN
  assign range_fault = |(address >> ADDR_W);
`else
  // Upper address bits alias onto the array; they are deliberately unused.
  logic unused_addr_upper;
  assign unused_addr_upper = |(address >> ADDR_W);
  assign range_fault       = 1'b0;
`endif

  // Decide whether the current cycle finishes an access (the edge into RESP).
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    complete = 1'b0;
    unique case (state)
      IDLE:    complete = req & !HAS_WAIT;
      WAIT:    complete = req & (cnt == 4'd0);
      default: complete = 1'b0;
    endcase
  end

  // A combined read+write request acts as a write. Gating with rst stops an
  // edge that arrives while reset is held from committing a store.
  assign do_write = complete & memwrite & ~range_fault & ~rst;
  assign do_read  = complete & memread & ~memwrite;

  // Array write port; the contents survive reset.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset on purpose, so it can map onto plain RAM cells.
    if (do_write) begin
      mem[idx] <= writedata;
    end
  end

  // Handshake FSM with its registered outputs: ready, err and readdata.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      readdata <= 16'h0000;
      ready    <= 1'b0;
      err      <= 1'b0;
    end else begin
      ready <= complete;
      err   <= complete & range_fault;

      if (do_read) begin
        readdata <= range_fault ? 16'h0000 : mem[idx];
      end

      unique case (state)
        IDLE: begin
          if (req) begin
            if (HAS_WAIT) begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end else begin
              state <= RESP;
            end
          end
        end
        WAIT: begin
          if (!req) begin
            // The initiator withdrew the request, so abandon the access silently.
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
